// File: rtl/stack_dmem_pkg.sv
// Shared definitions for the byte-serial data-memory responder.
//   - state_e     : responder states (idle, four byte cycles, response)
//   - DefAddrW    : default byte-address width (64-byte array)
//   - DefFcntW    : default fault counter width
//   - LaneShift*  : bit offset of each big-endian byte lane within the word
//   - lane_shift(): maps a lane index (0 = most significant) to its bit offset
package stack_dmem_pkg;

   localparam int unsigned DefAddrW = 6;
   localparam int unsigned DefFcntW = 8;

   typedef enum logic [2:0] {
      StIdle,
      StB0,
      StB1,
      StB2,
      StB3,
      StResp
   } state_e;

   localparam logic [4:0] LaneShift0 = 5'd24;
   localparam logic [4:0] LaneShift1 = 5'd16;
   localparam logic [4:0] LaneShift2 = 5'd8;
   localparam logic [4:0] LaneShift3 = 5'd0;

   function automatic logic [4:0] lane_shift(input logic [1:0] lane);
      logic [4:0] sh;
      unique case (lane)
         2'd0:    sh = LaneShift0;
         2'd1:    sh = LaneShift1;
         2'd2:    sh = LaneShift2;
         default: sh = LaneShift3;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational stack guard.
// Ports:
//   sp    in  32      stack pointer
//   base  in  32      stack base (highest stack byte address)
//   limit in  32      stack size in words
//   addr  in  ADDR_W  byte address being accessed
//   fault out 1       access lies in the stack region while sp is outside it
// The region lower bound is computed modulo 2**32; when it wraps above base the
// region is empty and no address can fault.
module stack_bounds_check
   import stack_dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic [31:0]       sp,
   input  logic [31:0]       base,
   input  logic [31:0]       limit,
   input  logic [ADDR_W-1:0] addr,
   output logic              fault
);

   logic [31:0] stack_low;
   logic [31:0] addr_ext;
   logic        in_stack;
   logic        sp_out;

   always_comb begin
      stack_low = base - (limit << 2);
      addr_ext  = {{(32 - ADDR_W){1'b0}}, addr};
      in_stack  = (addr_ext >= stack_low) && (addr_ext <= base);
      sp_out    = (sp > base) || (sp < stack_low);
      fault     = in_stack && sp_out;
   end

endmodule

// File: rtl/stack_dmem_responder.sv
// Byte-serial data-memory responder with optional stack guard.
// Accepts one 32-bit load/store at a time, moves it one byte per cycle through a
// 2**ADDR_W-byte big-endian array (address wraps), then presents a response.
// Build option: define STACK_GUARD_EN to enable the stack guard and fault counter;
// without it every access completes normally and stk_* are ignored.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only when idle and not in reset)
//   req_write             1 = store, 0 = load
//   req_addr              address of the word's most significant byte
//   req_wdata             store data
//   stk_sp/base/limit     stack pointer, base and limit (words), sampled at accept
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data (0 for stores and faulted accesses)
//   rsp_fault             access blocked by the stack guard
//   fault_count           saturating count of faulted accesses
module stack_dmem_responder
   import stack_dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned FCNT_W = DefFcntW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       stk_sp,
   input  logic [31:0]       stk_base,
   input  logic [31:0]       stk_limit,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic [FCNT_W-1:0] fault_count
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              fault_q;
   logic [7:0]        mem [Depth];

   logic              accept;
   logic              fault_now;
   logic              lane_active;
   logic [1:0]        lane;
   logic [ADDR_W-1:0] lane_addr;
   logic [4:0]        shift;

`ifdef STACK_GUARD_EN
   logic [FCNT_W-1:0] fcnt_q;

   stack_bounds_check #(
      .ADDR_W(ADDR_W)
   ) u_bounds (
      .sp   (stk_sp),
      .base (stk_base),
      .limit(stk_limit),
      .addr (req_addr),
      .fault(fault_now)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q <= '0;
      end else if (accept && fault_now && !(&fcnt_q)) begin
         fcnt_q <= fcnt_q + FCNT_W'(1);
      end
   end

   assign fault_count = fcnt_q;
`else
   logic unused_stk;

   assign unused_stk  = ^{stk_sp, stk_base, stk_limit};
   assign fault_now   = 1'b0;
   assign fault_count = '0;
`endif

   // Next state, handshake outputs and active byte lane.
   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      lane_active = 1'b0;
      lane        = 2'd0;
      unique case (state_q)
         StIdle: begin
            req_ready = !reset;
            if (req_valid && !reset) begin
               state_d = fault_now ? StResp : StB0;
            end
         end
         StB0: begin
            lane_active = 1'b1;
            lane        = 2'd0;
            state_d     = StB1;
         end
         StB1: begin
            lane_active = 1'b1;
            lane        = 2'd1;
            state_d     = StB2;
         end
         StB2: begin
            lane_active = 1'b1;
            lane        = 2'd2;
            state_d     = StB3;
         end
         StB3: begin
            lane_active = 1'b1;
            lane        = 2'd3;
            state_d     = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign accept    = req_valid && req_ready;
   // Natural ADDR_W-bit overflow gives the wrap within the array.
   assign lane_addr = addr_q + ADDR_W'(lane);
   assign shift     = lane_shift(lane);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            fault_q <= fault_now;
            rdata_q <= '0;
         end else if (lane_active && !write_q) begin
            rdata_q[shift +: 8] <= mem[lane_addr];
         end
      end
   end

   // The array has no reset; the byte of the current lane is still committed on an
   // edge that also sees reset, so only later lanes of an aborted store are lost.
   always_ff @(posedge clk) begin
      if (lane_active && write_q) begin
         mem[lane_addr] <= wdata_q[shift +: 8];
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_fault = fault_q;

endmodule

// File: tb/tb_stack_dmem_responder.sv
module tb_stack_dmem_responder;

   localparam int unsigned AW = 6;
   localparam int unsigned FW = 8;
   localparam int unsigned MemBytes = 64;

`ifdef STACK_GUARD_EN
   localparam bit GuardEn = 1'b1;
`else
   localparam bit GuardEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [31:0]   stk_sp;
   logic [31:0]   stk_base;
   logic [31:0]   stk_limit;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_fault;
   logic [FW-1:0] fault_count;

   always #5 clk = ~clk;

   stack_dmem_responder #(
      .ADDR_W(AW),
      .FCNT_W(FW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stk_sp     (stk_sp),
      .stk_base   (stk_base),
      .stk_limit  (stk_limit),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .fault_count(fault_count)
   );

   typedef struct {
      string       name;
      logic [31:0] rdata;
      bit          fault;
      int unsigned fcount;
      int          accept_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  model_mem [MemBytes];
   int unsigned model_fcount;
   int          checks;
   int          errors;
   int          cyc;
   bit          hold_low;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference: the stack occupies [base - 4*limit, base] (mod 2**32); an access there
   // faults when sp is not inside that same range.
   function automatic bit model_fault(input logic [AW-1:0] a, input logic [31:0] sp,
                                      input logic [31:0] base, input logic [31:0] limit);
      logic [31:0] low;
      logic [31:0] a32;
      bit          in_stack;
      bit          sp_ok;
      low      = base - limit * 4;
      a32      = 32'(a);
      in_stack = (a32 >= low) && (a32 <= base);
      sp_ok    = (sp >= low) && (sp <= base);
      return GuardEn && in_stack && !sp_ok;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_access(input string name, input bit wr, input logic [AW-1:0] a,
                            input logic [31:0] wd, input logic [31:0] sp,
                            input logic [31:0] base, input logic [31:0] limit);
      exp_t e;
      bit   got;
      int   idx;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      stk_sp    = sp;
      stk_base  = base;
      stk_limit = limit;
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s accept: req_ready stayed low, required 1 within 60 cycles", name);
         @(posedge clk);
         #1 req_valid = 1'b0;
         return;
      end
      e.name       = name;
      e.fault      = model_fault(a, sp, base, limit);
      e.rdata      = 32'h0;
      e.accept_cyc = cyc + 1;
      if (e.fault) begin
         if (model_fcount < (1 << FW) - 1) model_fcount++;
      end else begin
         for (int k = 0; k < 4; k++) begin
            idx = (int'(a) + k) % MemBytes;
            if (wr) model_mem[idx] = 8'(wd >> (24 - 8 * k));
            else e.rdata = {e.rdata[23:0], model_mem[idx]};
         end
      end
      e.fcount = model_fcount;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      // In-flight accesses must ignore later stack input changes.
      stk_sp    = $urandom;
      stk_base  = $urandom;
      stk_limit = $urandom_range(0, 3);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Randomised consumer backpressure.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: every cycle a response is shown it must match the head of the queue.
   initial begin : monitor
      bit   prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            prev_valid = 1'b0;
            continue;
         end
         if (rsp_valid === 1'b1) begin
            check("req_ready_in_resp", 32'(req_ready), 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: rsp_valid 1 with rdata %h, required no response",
                        rsp_rdata);
            end else begin
               e = exp_q[0];
               if (!prev_valid) begin
                  check({e.name, "_latency"}, 32'(cyc - e.accept_cyc + 1), e.fault ? 32'd1 : 32'd5);
               end
               check({e.name, "_rdata"}, rsp_rdata, e.rdata);
               check({e.name, "_fault"}, 32'(rsp_fault), 32'(e.fault));
               check({e.name, "_fcount"}, 32'(fault_count), e.fcount);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_valid = (rsp_valid === 1'b1) && !rsp_ready;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] w;
      bit          got;
      checks       = 0;
      errors       = 0;
      model_fcount = 0;
      hold_low     = 1'b0;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      stk_sp       = '0;
      stk_base     = '0;
      stk_limit    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_rsp_fault", 32'(rsp_fault), 32'h0);
      check("reset_fault_count", 32'(fault_count), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Give the whole array known contents (sp = base = limit = 0 never faults).
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         do_access("fill", 1'b1, AW'(4 * i), w, 0, 0, 0);
      end

      do_access("st_deadbeef", 1'b1, 6'h10, 32'hDEADBEEF, 0, 0, 0);
      do_access("ld_deadbeef", 1'b0, 6'h10, 32'h0, 0, 0, 0);
      do_access("st_wrap", 1'b1, 6'h3E, 32'h11223344, 0, 0, 0);
      do_access("ld_wrap", 1'b0, 6'h3E, 32'h0, 0, 0, 0);
      do_access("ld_wrap_lo", 1'b0, 6'h00, 32'h0, 0, 0, 0);

      // Stack region 0x2C..0x3C with sp out of bounds.
      do_access("st_guard", 1'b1, 6'h30, 32'hCAFEF00D, 32'h40, 32'h3C, 32'd4);
      do_access("ld_guard", 1'b0, 6'h30, 32'h0, 32'h40, 32'h3C, 32'd4);
      do_access("st_outside", 1'b1, 6'h04, 32'h5A5A0F0F, 32'h40, 32'h3C, 32'd4);
      do_access("ld_after_guard", 1'b0, 6'h30, 32'h0, 0, 0, 0);
      do_access("ld_outside", 1'b0, 6'h04, 32'h0, 0, 0, 0);

      // Backpressure: hold rsp_ready low for three response cycles with a request waiting.
      drain();
      hold_low = 1'b1;
      do_access("bp_load", 1'b0, 6'h10, 32'h0, 0, 0, 0);
      fork
         begin
            repeat (7) @(posedge clk);
            #1 hold_low = 1'b0;
         end
         do_access("bp_next", 1'b1, 6'h08, 32'h0BADC0DE, 0, 0, 0);
      join
      do_access("bp_check", 1'b0, 6'h08, 32'h0, 0, 0, 0);

      // Reset during B1 of a store: first two bytes land, the rest do not.
      drain();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 6'h20;
      req_wdata = 32'hA1B2C3D4;
      stk_sp    = '0;
      stk_base  = '0;
      stk_limit = '0;
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("abort_accept", 32'(got), 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_mem[8'h20] = 8'hA1;
      model_mem[8'h21] = 8'hB2;
      model_fcount     = 0;
      @(negedge clk);
      check("ready_after_reset", 32'(req_ready), 32'h1);
      check("fcount_after_reset", 32'(fault_count), 32'h0);
      @(posedge clk);
      #1;
      do_access("ld_aborted", 1'b0, 6'h20, 32'h0, 0, 0, 0);

      // Randomised traffic against the reference model.
      for (int i = 0; i < 150; i++) begin
         w = $urandom;
         do_access("rand", 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), w,
                   32'($urandom_range(0, 80)), 32'($urandom_range(0, 70)),
                   32'($urandom_range(0, 12)));
      end

      // Push the fault counter past its saturation point.
      for (int i = 0; i < 260; i++) begin
         do_access("sat", 1'b0, 6'h30, 32'h0, 32'h40, 32'h3C, 32'd4);
      end
      do_access("final_ld", 1'b0, 6'h10, 32'h0, 0, 0, 0);

      drain();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_dmem_responder.md
# stack_dmem_responder

Multi-cycle, byte-serial data-memory responder that sits on the processor's data-memory port as the target end of the load/store interface. It accepts one 32-bit word request at a time over a valid/ready handshake, moves the word one byte per cycle into or out of a 64-byte big-endian byte array, and returns completion over a second valid/ready handshake. A stack guard checks each access against the stack pointer, base and limit values taken from the register file, and faults any access that touches the stack region while the stack is out of bounds.

## Interface
- ADDR_W, 6, byte-address width; memory depth is 2**ADDR_W bytes
- FCNT_W, 8, fault counter width
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE and when reset is low
- req_write  in  1  1 = store word, 0 = load word
- req_addr  in  ADDR_W  byte address of the word's most significant byte
- req_wdata  in  32  store data
- stk_sp  in  32  stack pointer (r14)
- stk_base  in  32  stack base address (r12)
- stk_limit  in  32  stack limit in words (r13)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load data; 0 for stores and for faulted loads
- rsp_fault  out  1  access was blocked by the stack guard
- fault_count  out  FCNT_W  saturating count of faulted accesses

## Operation
- States: IDLE, B0, B1, B2, B3, RESP.
- IDLE: a request is accepted when req_valid && req_ready. Address, write flag, write data and the fault decision are latched in that cycle. Next state is B0, or RESP if the access faulted.
- Bk (k = 0..3): the byte lane at (addr + k) mod 2**ADDR_W is accessed, so the address wraps within the array.
  - Big-endian: lane 0 holds bits [31:24] and lane 3 holds bits [7:0].
  - Store: the byte is written at the end of Bk.
  - Load: the byte is captured into the matching slice of rsp_rdata.
- RESP: rsp_valid = 1. rsp_rdata and rsp_fault are held stable until rsp_valid && rsp_ready, then the block returns to IDLE.
- Fault decision:
  - stack_low = stk_base - (stk_limit << 2), computed modulo 2**32.
  - in_stack = stack_low <= zext(req_addr) <= stk_base, as an unsigned compare.
  - fault = in_stack && (stk_sp > stk_base || stk_sp < stack_low).
  - If stack_low wraps above stk_base, in_stack is false for every address; there is no special-casing.
- A faulted access writes no bytes and returns rsp_rdata = 0 with rsp_fault = 1.
- fault_count increments by 1 on each accepted faulted request and saturates at all-ones.
- The memory array is not cleared by reset.

## Timing
- Reset values: state IDLE, req_ready 0 while reset is high, rsp_valid 0, rsp_rdata 0, rsp_fault 0, fault_count 0.
- Request accepted at edge N, non-faulted: B0 through B3 occupy cycles N+1 to N+4, and rsp_valid rises in cycle N+5.
- Faulted request accepted at edge N: rsp_valid rises in cycle N+1.
- Minimum spacing between accepted requests is 6 cycles (non-faulted) or 2 cycles (faulted), assuming rsp_ready is held high.
- req_ready is 0 from B0 through RESP. No request is queued or buffered.
- Stack inputs are sampled only in the accept cycle. Later changes to them do not affect an access already in flight.
- Reset asserted mid-access: the access is aborted at that edge and no response is issued. Bytes already written in earlier Bk states remain in memory.
- rsp_ready high while rsp_valid is 0 has no effect.

## Configuration
- STACK_GUARD_EN
  - Defined: stack guard and fault behaviour exactly as described above.
  - Undefined: fault is constant 0, every access performs all four byte cycles, rsp_fault and fault_count stay 0, and the stk_* inputs are ignored (ports kept).

## Structure
- Package stack_dmem_pkg holds:
  - the state enum (IDLE, B0, B1, B2, B3, RESP)
  - default ADDR_W and FCNT_W
  - the byte-lane shift constants (24, 16, 8, 0)
- One combinational sub-module, stack_bounds_check (inputs: sp, base, limit, addr; output: fault), compiled away when STACK_GUARD_EN is undefined.

## Test plan
- Store 0xDEADBEEF to addr 0x10, accepted at edge N, rsp_ready held high:
  - rsp_valid rises in cycle N+5 with rsp_fault 0.
  - mem[0x10..0x13] = DE AD BE EF.
- Load from addr 0x10 afterwards: rsp_rdata = 0xDEADBEEF in cycle N+5.
- Store 0x11223344 to addr 0x3E (wrap case): mem[0x3E] = 11, mem[0x3F] = 22, mem[0x00] = 33, mem[0x01] = 44; a load from 0x3E returns 0x11223344.
- Stack guard, with base = 0x3C, limit = 4 (stack_low 0x2C), sp = 0x40:
  - Store to 0x30: rsp_valid in cycle N+1, rsp_fault 1, memory unchanged, fault_count = 1.
  - Store to 0x04 with the same settings: normal 5-cycle store, rsp_fault 0.
- Backpressure: rsp_ready held low for 3 cycles while in RESP. rsp_valid stays high, rsp_rdata stays stable, req_ready stays 0, and a waiting req_valid is not accepted until after the handshake.
- Reset pulsed during B1 of a store of 0xA1B2C3D4 to 0x20: mem[0x20] = A1, mem[0x21] = B2, mem[0x22..0x23] unchanged, no rsp_valid, and req_ready = 1 in the first cycle after reset deasserts.
